// File: rtl/fft_pkg.sv
// Shared types and constants for the 4-point streaming FFT.
// Imported by the interface, butterfly and top.
package fft_pkg;

    typedef enum logic [1:0] {
        LOAD,
        STAGE1,
        STAGE2,
        OUTPUT
    } state_t;

    localparam int NPOINT = 4;
    localparam int GROWTH = 2;

endpackage

// File: rtl/fft4_stream_if.sv
// Sample-in / result-out handshake bundle for fft4_stream.
// slave = the transform block, master = the producer/consumer side.
interface fft4_stream_if #(
    parameter int DW = 8
);
    import fft_pkg::*;

    localparam int OW = DW + GROWTH;

    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] in_re;
    logic signed [DW-1:0] in_im;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [OW-1:0] out_re;
    logic signed [OW-1:0] out_im;
    logic [1:0]           out_idx;

    modport master (
        output in_valid, in_re, in_im, out_ready,
        input  in_ready, out_valid, out_re, out_im, out_idx
    );

    modport slave (
        input  in_valid, in_re, in_im, out_ready,
        output in_ready, out_valid, out_re, out_im, out_idx
    );

endinterface

// File: rtl/fft_bfly.sv
// Complex radix-2 butterfly: sum and difference with one bit of growth.
// Operands are sign-extended before the add/sub so nothing can wrap.
module fft_bfly #(
    parameter int W = 8
) (
    input  logic signed [W-1:0] a_re_i,
    input  logic signed [W-1:0] a_im_i,
    input  logic signed [W-1:0] b_re_i,
    input  logic signed [W-1:0] b_im_i,
    output logic signed [W:0]   s_re_o,
    output logic signed [W:0]   s_im_o,
    output logic signed [W:0]   d_re_o,
    output logic signed [W:0]   d_im_o
);

    logic signed [W:0] a_re;
    logic signed [W:0] a_im;
    logic signed [W:0] b_re;
    logic signed [W:0] b_im;

    assign a_re = {a_re_i[W-1], a_re_i};
    assign a_im = {a_im_i[W-1], a_im_i};
    assign b_re = {b_re_i[W-1], b_re_i};
    assign b_im = {b_im_i[W-1], b_im_i};

    assign s_re_o = a_re + b_re;
    assign s_im_o = a_im + b_im;
    assign d_re_o = a_re - b_re;
    assign d_im_o = a_im - b_im;

endmodule

// File: rtl/fft4_stream.sv
// Streaming 4-point DFT: load 4 samples, two butterfly stages, emit 4 bins.
// Define FFT4_STREAM_INVERSE_EN to add the 'inverse' port (unscaled IDFT).
module fft4_stream
    import fft_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic         clk,
    input  logic         rst_n,
`ifdef FFT4_STREAM_INVERSE_EN
    input  logic         inverse,
`endif
    fft4_stream_if.slave s,
    output logic         busy
);

    localparam int OW = DW + GROWTH;
    localparam int SW = DW + 1;

    state_t               state_q;
    logic [1:0]           cnt_q;
    logic [1:0]           idx_q;
    logic                 in_ready_q;
    logic                 out_valid_q;
    logic                 busy_q;
    logic                 inv_q;
    logic                 inv_d;
    logic signed [OW-1:0] out_re_q;
    logic signed [OW-1:0] out_im_q;

    logic signed [DW-1:0] x_re_q [NPOINT];
    logic signed [DW-1:0] x_im_q [NPOINT];
    logic signed [SW-1:0] a_re_q, a_im_q, b_re_q, b_im_q;
    logic signed [SW-1:0] c_re_q, c_im_q, d_re_q, d_im_q;
    logic signed [OW-1:0] f_re_q [NPOINT];
    logic signed [OW-1:0] f_im_q [NPOINT];

    logic signed [SW-1:0] a_re_d, a_im_d, b_re_d, b_im_d;
    logic signed [SW-1:0] c_re_d, c_im_d, d_re_d, d_im_d;
    logic signed [SW-1:0] m_im;
    logic signed [OW-1:0] f0_re, f0_im, f1_re, f1_im;
    logic signed [OW-1:0] f2_re, f2_im, f3_re, f3_im;

`ifdef FFT4_STREAM_INVERSE_EN
    assign inv_d = inverse;
`else
    assign inv_d = 1'b0;
`endif

    fft_bfly #(.W(DW)) u_s1_ac (
        .a_re_i(x_re_q[0]), .a_im_i(x_im_q[0]),
        .b_re_i(x_re_q[2]), .b_im_i(x_im_q[2]),
        .s_re_o(a_re_d),    .s_im_o(a_im_d),
        .d_re_o(b_re_d),    .d_im_o(b_im_d)
    );

    fft_bfly #(.W(DW)) u_s1_bd (
        .a_re_i(x_re_q[1]), .a_im_i(x_im_q[1]),
        .b_re_i(x_re_q[3]), .b_im_i(x_im_q[3]),
        .s_re_o(c_re_d),    .s_im_o(c_im_d),
        .d_re_o(d_re_d),    .d_im_o(d_im_d)
    );

    fft_bfly #(.W(SW)) u_s2_even (
        .a_re_i(a_re_q), .a_im_i(a_im_q),
        .b_re_i(c_re_q), .b_im_i(c_im_q),
        .s_re_o(f0_re),  .s_im_o(f0_im),
        .d_re_o(f2_re),  .d_im_o(f2_im)
    );

    // -j*d = d.im - j*d.re; the negation fits since |d.re| < 2**DW
    assign m_im = -d_re_q;

    fft_bfly #(.W(SW)) u_s2_odd (
        .a_re_i(b_re_q), .a_im_i(b_im_q),
        .b_re_i(d_im_q), .b_im_i(m_im),
        .s_re_o(f1_re),  .s_im_o(f1_im),
        .d_re_o(f3_re),  .d_im_o(f3_im)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= LOAD;
            cnt_q       <= '0;
            idx_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            inv_q       <= 1'b0;
            out_re_q    <= '0;
            out_im_q    <= '0;
            a_re_q      <= '0;
            a_im_q      <= '0;
            b_re_q      <= '0;
            b_im_q      <= '0;
            c_re_q      <= '0;
            c_im_q      <= '0;
            d_re_q      <= '0;
            d_im_q      <= '0;
            for (int i = 0; i < NPOINT; i++) begin
                x_re_q[i] <= '0;
                x_im_q[i] <= '0;
                f_re_q[i] <= '0;
                f_im_q[i] <= '0;
            end
        end else begin
            unique case (state_q)
                LOAD: begin
                    if (s.in_valid) begin
                        x_re_q[cnt_q] <= s.in_re;
                        x_im_q[cnt_q] <= s.in_im;
                        cnt_q         <= cnt_q + 2'd1;
                        if (cnt_q == 2'd0) inv_q <= inv_d;
                        if (cnt_q == 2'd3) begin
                            state_q    <= STAGE1;
                            in_ready_q <= 1'b0;
                            busy_q     <= 1'b1;
                        end
                    end
                end
                STAGE1: begin
                    a_re_q  <= a_re_d;
                    a_im_q  <= a_im_d;
                    b_re_q  <= b_re_d;
                    b_im_q  <= b_im_d;
                    c_re_q  <= c_re_d;
                    c_im_q  <= c_im_d;
                    d_re_q  <= d_re_d;
                    d_im_q  <= d_im_d;
                    state_q <= STAGE2;
                end
                STAGE2: begin
                    // Swapping X1/X3 turns the forward kernel into the IDFT
                    f_re_q[0]   <= f0_re;
                    f_im_q[0]   <= f0_im;
                    f_re_q[2]   <= f2_re;
                    f_im_q[2]   <= f2_im;
                    f_re_q[1]   <= inv_q ? f3_re : f1_re;
                    f_im_q[1]   <= inv_q ? f3_im : f1_im;
                    f_re_q[3]   <= inv_q ? f1_re : f3_re;
                    f_im_q[3]   <= inv_q ? f1_im : f3_im;
                    out_re_q    <= f0_re;
                    out_im_q    <= f0_im;
                    idx_q       <= 2'd0;
                    out_valid_q <= 1'b1;
                    state_q     <= OUTPUT;
                end
                OUTPUT: begin
                    if (s.out_ready) begin
                        if (idx_q == 2'd3) begin
                            idx_q       <= 2'd0;
                            out_valid_q <= 1'b0;
                            in_ready_q  <= 1'b1;
                            busy_q      <= 1'b0;
                            state_q     <= LOAD;
                        end else begin
                            idx_q    <= idx_q + 2'd1;
                            out_re_q <= f_re_q[idx_q + 2'd1];
                            out_im_q <= f_im_q[idx_q + 2'd1];
                        end
                    end
                end
                default: state_q <= LOAD;
            endcase
        end
    end

    assign s.in_ready  = in_ready_q;
    assign s.out_valid = out_valid_q;
    assign s.out_re    = out_re_q;
    assign s.out_im    = out_im_q;
    assign s.out_idx   = idx_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_fft4_stream.sv
// Directed bench for fft4_stream: impulse, DC, tone, extremes,
// backpressure, back-to-back frames and mid-frame resets.
module tb_fft4_stream;
    import fft_pkg::*;

    localparam int DW = 8;
    localparam int OW = DW + GROWTH;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy;
    int   checks = 0;
    int   errors = 0;

    int                   fr_re [4];
    int                   fr_im [4];
    logic signed [OW-1:0] got_re [4];
    logic signed [OW-1:0] got_im [4];
    logic [1:0]           got_idx [4];
    bit                   got_tmo;
    bit                   snd_tmo;

`ifdef FFT4_STREAM_INVERSE_EN
    logic inv_tb = 1'b0;
`endif

    fft4_stream_if #(.DW(DW)) bus ();

    fft4_stream #(.DW(DW)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
`ifdef FFT4_STREAM_INVERSE_EN
        .inverse(inv_tb),
`endif
        .s      (bus.slave),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives fr_re/fr_im as x0..x3; returns #1 after the edge taking x3.
    task automatic send_frame(input int gap);
        int n;
        snd_tmo = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (gap > 0 && i > 0) begin
                bus.in_valid = 1'b0;
                repeat (gap) step();
            end
            bus.in_valid = 1'b1;
            bus.in_re    = DW'(fr_re[i]);
            bus.in_im    = DW'(fr_im[i]);
            n = 0;
            while (bus.in_ready !== 1'b1 && n < 50) begin
                step();
                n++;
            end
            if (n >= 50) snd_tmo = 1'b1;
            step();
        end
        bus.in_valid = 1'b0;
    endtask

    // Accepts four results with out_ready held high.
    task automatic collect();
        int n;
        got_tmo = 1'b0;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (bus.out_valid !== 1'b1 && n < 50) begin
                step();
                n++;
            end
            if (n >= 50) got_tmo = 1'b1;
            got_re[k]  = bus.out_re;
            got_im[k]  = bus.out_im;
            got_idx[k] = bus.out_idx;
            step();
        end
    endtask

    task automatic test_reset();
        bus.in_valid  = 1'b0;
        bus.in_re     = '0;
        bus.in_im     = '0;
        bus.out_ready = 1'b0;
        rst_n         = 1'b0;
        repeat (3) step();
        checks++;
        if (bus.out_valid !== 1'b0 || busy !== 1'b0 || bus.out_idx !== 2'd0) begin
            errors++;
            $display("FAIL reset_ctrl: valid=%b busy=%b idx=%0d, want 0 0 0",
                     bus.out_valid, busy, bus.out_idx);
        end
        checks++;
        if (bus.out_re !== '0 || bus.out_im !== '0) begin
            errors++;
            $display("FAIL reset_data: re=%0d im=%0d, want 0 0", bus.out_re, bus.out_im);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        checks++;
        if (bus.in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: in_ready=%b busy=%b, want 1 0", bus.in_ready, busy);
        end
    endtask

    task automatic test_impulse();
        int ere [4] = '{1, 1, 1, 1};
        int eim [4] = '{0, 0, 0, 0};
        fr_re = '{1, 0, 0, 0};
        fr_im = '{0, 0, 0, 0};
        send_frame(0);
        checks++;
        if (bus.in_ready !== 1'b0 || busy !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL impulse_stage1: ready=%b busy=%b valid=%b, want 0 1 0",
                     bus.in_ready, busy, bus.out_valid);
        end
        step();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL latency_early: out_valid=%b one edge after x3, want 0", bus.out_valid);
        end
        // Visible after the second edge, so first sampled high at the third.
        step();
        checks++;
        if (bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL latency: out_valid=%b two edges after x3, want 1", bus.out_valid);
        end
        collect();
        checks++;
        if (snd_tmo || got_tmo) begin
            errors++;
            $display("FAIL impulse_timeout: send=%b collect=%b, want 0 0", snd_tmo, got_tmo);
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (got_re[k] !== OW'(ere[k]) || got_im[k] !== OW'(eim[k]) || got_idx[k] !== 2'(k)) begin
                errors++;
                $display("FAIL impulse X%0d: got %0d,%0d idx %0d want %0d,%0d idx %0d",
                         k, got_re[k], got_im[k], got_idx[k], ere[k], eim[k], k);
            end
        end
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL impulse_reload: ready=%b valid=%b busy=%b, want 1 0 0",
                     bus.in_ready, bus.out_valid, busy);
        end
    endtask

    task automatic test_dc_gaps();
        int ere [4] = '{20, 0, 0, 0};
        fr_re = '{5, 5, 5, 5};
        fr_im = '{0, 0, 0, 0};
        send_frame(3);
        collect();
        checks++;
        if (snd_tmo || got_tmo) begin
            errors++;
            $display("FAIL dc_timeout: send=%b collect=%b, want 0 0", snd_tmo, got_tmo);
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (got_re[k] !== OW'(ere[k]) || got_im[k] !== '0 || got_idx[k] !== 2'(k)) begin
                errors++;
                $display("FAIL dc X%0d: got %0d,%0d idx %0d want %0d,0 idx %0d",
                         k, got_re[k], got_im[k], got_idx[k], ere[k], k);
            end
        end
    endtask

    task automatic test_tone();
        int ere [4] = '{0, 4, 0, 0};
        fr_re = '{1, 0, -1, 0};
        fr_im = '{0, 1, 0, -1};
        send_frame(0);
        collect();
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (got_re[k] !== OW'(ere[k]) || got_im[k] !== '0 || got_tmo) begin
                errors++;
                $display("FAIL tone X%0d: got %0d,%0d want %0d,0 (tmo %b)",
                         k, got_re[k], got_im[k], ere[k], got_tmo);
            end
        end
    endtask

`ifdef FFT4_STREAM_INVERSE_EN
    task automatic test_tone_inverse();
        int ere [4] = '{0, 0, 0, 4};
        fr_re  = '{1, 0, -1, 0};
        fr_im  = '{0, 1, 0, -1};
        inv_tb = 1'b1;
        send_frame(0);
        inv_tb = 1'b0;
        collect();
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (got_re[k] !== OW'(ere[k]) || got_im[k] !== '0 || got_tmo) begin
                errors++;
                $display("FAIL itone X%0d: got %0d,%0d want %0d,0 (tmo %b)",
                         k, got_re[k], got_im[k], ere[k], got_tmo);
            end
        end
    endtask
`endif

    task automatic test_extremes();
        int ere [4] = '{-512, 0, 0, 0};
        fr_re = '{-128, -128, -128, -128};
        fr_im = '{-128, -128, -128, -128};
        send_frame(0);
        collect();
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (got_re[k] !== OW'(ere[k]) || got_im[k] !== OW'(ere[k]) || got_tmo) begin
                errors++;
                $display("FAIL extreme X%0d: got %0d,%0d want %0d,%0d (tmo %b)",
                         k, got_re[k], got_im[k], ere[k], ere[k], got_tmo);
            end
        end
    endtask

    task automatic test_backpressure();
        int ere [4] = '{6, -3, -8, 9};
        int eim [4] = '{6, 3, -2, 1};
        int n;
        fr_re = '{1, 3, -2, 4};
        fr_im = '{2, -1, 0, 5};
        bus.out_ready = 1'b0;
        send_frame(0);
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        checks++;
        if (n >= 50 || bus.out_idx !== 2'd0 || bus.out_re !== OW'(ere[0]) ||
            bus.out_im !== OW'(eim[0])) begin
            errors++;
            $display("FAIL bp_X0: got %0d,%0d idx %0d want %0d,%0d idx 0 (waited %0d)",
                     bus.out_re, bus.out_im, bus.out_idx, ere[0], eim[0], n);
        end
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step();
            checks++;
            if (bus.out_idx !== 2'd1 || bus.out_re !== OW'(ere[1]) ||
                bus.out_im !== OW'(eim[1]) || bus.in_ready !== 1'b0 ||
                bus.out_valid !== 1'b1) begin
                errors++;
                $display("FAIL bp_hold c%0d: got %0d,%0d idx %0d ready %b valid %b want %0d,%0d idx 1 ready 0 valid 1",
                         c, bus.out_re, bus.out_im, bus.out_idx, bus.in_ready,
                         bus.out_valid, ere[1], eim[1]);
            end
        end
        bus.out_ready = 1'b1;
        for (int k = 1; k < 4; k++) begin
            checks++;
            if (bus.out_idx !== 2'(k) || bus.out_re !== OW'(ere[k]) ||
                bus.out_im !== OW'(eim[k])) begin
                errors++;
                $display("FAIL bp X%0d: got %0d,%0d idx %0d want %0d,%0d idx %0d",
                         k, bus.out_re, bus.out_im, bus.out_idx, ere[k], eim[k], k);
            end
            step();
        end
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_done: ready=%b valid=%b, want 1 0", bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_back_to_back();
        int are [4] = '{1, 0, -1, 0};
        int aim [4] = '{0, -1, 0, 1};
        int bre [4] = '{2, 0, -2, 0};
        int bim [4] = '{0, 2, 0, -2};
        fr_re = '{0, 1, 0, 0};
        fr_im = '{0, 0, 0, 0};
        send_frame(0);
        // Junk held valid while busy must be ignored.
        bus.in_valid = 1'b1;
        bus.in_re    = 8'sd50;
        bus.in_im    = -8'sd7;
        collect();
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (got_re[k] !== OW'(are[k]) || got_im[k] !== OW'(aim[k]) || got_tmo) begin
                errors++;
                $display("FAIL b2b_a X%0d: got %0d,%0d want %0d,%0d",
                         k, got_re[k], got_im[k], are[k], aim[k]);
            end
        end
        fr_re = '{0, 0, 0, 2};
        send_frame(0);
        collect();
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (got_re[k] !== OW'(bre[k]) || got_im[k] !== OW'(bim[k]) || got_tmo) begin
                errors++;
                $display("FAIL b2b_b X%0d: got %0d,%0d want %0d,%0d",
                         k, got_re[k], got_im[k], bre[k], bim[k]);
            end
        end
    endtask

    task automatic test_reset_stage2();
        fr_re = '{7, 1, -3, 2};
        fr_im = '{1, 1, 1, 1};
        send_frame(0);
        step();
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || busy !== 1'b0 || bus.out_idx !== 2'd0) begin
            errors++;
            $display("FAIL rst_s2: valid=%b busy=%b idx=%0d, want 0 0 0",
                     bus.out_valid, busy, bus.out_idx);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        fr_re = '{2, 0, 0, 0};
        fr_im = '{0, 0, 0, 0};
        send_frame(0);
        collect();
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (got_re[k] !== OW'(2) || got_im[k] !== '0 || got_tmo) begin
                errors++;
                $display("FAIL rst_s2 X%0d: got %0d,%0d want 2,0", k, got_re[k], got_im[k]);
            end
        end
    endtask

    task automatic test_reset_load();
        bus.in_valid = 1'b1;
        bus.in_re    = 8'sd9;
        bus.in_im    = 8'sd9;
        repeat (2) step();
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        fr_re = '{3, 0, 0, 0};
        fr_im = '{0, 0, 0, 0};
        send_frame(0);
        collect();
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (got_re[k] !== OW'(3) || got_im[k] !== '0 || got_tmo) begin
                errors++;
                $display("FAIL rst_load X%0d: got %0d,%0d want 3,0", k, got_re[k], got_im[k]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_impulse();
        test_dc_gaps();
        test_tone();
`ifdef FFT4_STREAM_INVERSE_EN
        test_tone_inverse();
`endif
        test_extremes();
        test_backpressure();
        test_back_to_back();
        test_reset_stage2();
        test_reset_load();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
